stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//   Shares one PushdownStack (8-bit data, 1K entries) between two requesters.
//   Each requester issues push/pop via a req/ack handshake. The arbiter
//   serialises requests round-robin, drives the stack's PushPop/Enable, and
//   rejects pushes when the stack is full and pops when it is empty.
//   Sits between the client logic and the PushdownStack instance.
// PARAMETERS
//   DW   8   data width; must match the stack's I/O width
// PORTS
//   CLK        in   1   system clock, rising edge
//   Reset      in   1   asynchronous, active-low reset
//   Req0       in   1   requester 0 request; held high until Ack0
//   Op0        in   1   requester 0 op: 0=push, 1=pop; stable while Req0
//   WrData0    in   DW  requester 0 push data; stable while Req0
//   Ack0       out  1   one-cycle completion pulse to requester 0
//   Req1/Op1/WrData1/Ack1  same as above for requester 1
//   Err        out  1   valid with the Ack pulse: 1 = op rejected
//   RdData     out  DW  last successfully popped value
//   Busy       out  1   1 whenever FSM is not IDLE
//   StkI       out  DW  to stack I
//   StkO       in   DW  from stack O
//   StkPushPop out  1   to stack PushPop (0=push, 1=pop)
//   StkEnable  out  1   to stack Enable
//   StkEmpty   in   1   stack Empty flag
//   StkFull    in   1   stack Full flag
// BEHAVIOUR
//   Reset (Reset=0, async): FSM=IDLE, last-grant ptr=1 (requester 0 wins
//     first tie). Ack0, Ack1, Err, Busy, StkEnable, StkPushPop = 0.
//     StkI and RdData = 0.
//   FSM states: IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: if any Req, pick a winner and latch its id, Op and WrData -> ISSUE.
//     Both requesting: grant the one NOT granted last.
//   ISSUE (exactly 1 cycle):
//     - reject = (op==push & StkFull) | (op==pop & StkEmpty), sampled this cycle.
//     - reject: StkEnable=0; no stack access.
//     - else: StkEnable=1, StkPushPop=op, StkI=latched data.
//       On a pop, RdData <= StkO at the closing edge.
//     -> RESP.
//   RESP: Ack[winner]=1 for one cycle; Err=reject; update last-grant ptr
//     -> IDLE.
//   Latency and throughput:
//     - Req sampled in IDLE at cycle n -> Ack at cycle n+2.
//     - Max one op per 3 cycles.
//     - A Req held high after its Ack is treated as a new request and
//       re-arbitrated.
//   StkEnable is high only in non-rejected ISSUE cycles; never asserted twice
//     per grant.
//   RdData changes only on a successful pop; push and error leave it unchanged.
//   Rejected ops do not affect the grant pointer differently than successful
//     ones: the pointer always advances.
//   Reset mid-op: outputs clear immediately and no Ack is issued. The in-flight
//     op is lost. The stack's own reset is managed by the system, not here.
//   Req dropped before Ack: protocol violation; the latched op still completes.
// CONFIGURATION
//   STACK_ARB_FIXED_PRI_EN defined: fixed priority; requester 0 always wins
//     when both request, and the last-grant ptr is unused.
//   Undefined (default): round-robin as above.
// TESTING
//   1. Reset with both Req=0 -> all outputs 0, Busy=0.
//   2. Req0 push 8'hA5 on empty stack -> StkEnable=1 with StkPushPop=0 and
//      StkI=8'hA5 for 1 cycle; Ack0 two cycles after Req0 is sampled; Err=0.
//   3. Continuing test 2, Req1 pop -> RdData=8'hA5, Ack1 with Err=0; then
//      Req0 pop on the now-empty stack -> Ack0 with Err=1, StkEnable stays 0,
//      RdData stays 8'hA5.
//   4. Req0 and Req1 both held high with pushes of 8'h01 and 8'h02 ->
//      grants alternate 0,1,0,1.
//      With STACK_ARB_FIXED_PRI_EN: Ack0 every time, Ack1 never.
//   5. Fill the stack until StkFull=1, then push 8'hFF -> Err=1, no
//      StkEnable, Ack still returned.
//   6. Assert Reset during ISSUE -> no Ack; StkEnable drops to 0
//      asynchronously; next request is granted to requester 0.

Source files
------------

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one pushdown stack between two req/ack requesters.
// Define STACK_ARB_FIXED_PRI_EN for fixed priority (requester 0 always wins ties).
module stack_arbiter #(
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Op0,
    input  logic [DW-1:0] WrData0,
    output logic          Ack0,
    input  logic          Req1,
    input  logic          Op1,
    input  logic [DW-1:0] WrData1,
    output logic          Ack1,
    output logic          Err,
    output logic [DW-1:0] RdData,
    output logic          Busy,
    output logic [DW-1:0] StkI,
    input  logic [DW-1:0] StkO,
    output logic          StkPushPop,
    output logic          StkEnable,
    input  logic          StkEmpty,
    input  logic          StkFull
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          r_win;
    logic          r_op;
    logic [DW-1:0] r_data;
    logic          r_reject;
    logic [DW-1:0] r_rd_data;

    logic          w_req_any;
    logic          w_grant;
    logic          w_reject;

    assign w_req_any = Req0 | Req1;
    assign w_reject  = r_op ? StkEmpty : StkFull;

`ifdef STACK_ARB_FIXED_PRI_EN
    assign w_grant = ~Req0;
`else
    logic r_last;

    // Ties go to whichever requester was not served last.
    assign w_grant = (Req0 & Req1) ? ~r_last : Req1;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_last <= 1'b1;
        end else if (r_state == StResp) begin
            r_last <= r_win;
        end
    end
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= StIdle;
            r_win     <= 1'b0;
            r_op      <= 1'b0;
            r_data    <= '0;
            r_reject  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_req_any) begin
                r_win  <= w_grant;
                r_op   <= w_grant ? Op1 : Op0;
                r_data <= w_grant ? WrData1 : WrData0;
            end
            if (r_state == StIssue) begin
                r_reject <= w_reject;
                if (!w_reject && r_op) begin
                    r_rd_data <= StkO;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        Ack0         = 1'b0;
        Ack1         = 1'b0;
        Err          = 1'b0;
        StkEnable    = 1'b0;
        StkPushPop   = 1'b0;
        StkI         = '0;
        unique case (r_state)
            StIdle: begin
                if (w_req_any) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                if (!w_reject) begin
                    StkEnable  = 1'b1;
                    StkPushPop = r_op;
                    StkI       = r_data;
                end
                w_state_next = StResp;
            end
            StResp: begin
                Ack0         = ~r_win;
                Ack1         = r_win;
                Err          = r_reject;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign Busy   = (r_state != StIdle);
    assign RdData = r_rd_data;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural 1K-entry stack model.
module tb_stack_arbiter;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Req0, Op0, Req1, Op1;
    logic [DW-1:0] WrData0, WrData1;
    logic          Ack0, Ack1, Err, Busy, StkPushPop, StkEnable, StkEmpty, StkFull;
    logic [DW-1:0] RdData, StkI, StkO;

    stack_arbiter #(.DW(DW)) dut (
        .CLK(CLK), .Reset(Reset),
        .Req0(Req0), .Op0(Op0), .WrData0(WrData0), .Ack0(Ack0),
        .Req1(Req1), .Op1(Op1), .WrData1(WrData1), .Ack1(Ack1),
        .Err(Err), .RdData(RdData), .Busy(Busy),
        .StkI(StkI), .StkO(StkO), .StkPushPop(StkPushPop), .StkEnable(StkEnable),
        .StkEmpty(StkEmpty), .StkFull(StkFull)
    );

    always #5 CLK = ~CLK;

    // Behavioural stack: top of stack is always visible on StkO.
    logic [DW-1:0] stk_mem [DEPTH];
    int            stk_sp = 0;

    always_comb begin
        StkO = (stk_sp > 0) ? stk_mem[stk_sp-1] : '0;
    end
    assign StkEmpty = (stk_sp == 0);
    assign StkFull  = (stk_sp == DEPTH);

    always @(posedge CLK) begin
        if (StkEnable) begin
            if (!StkPushPop) begin
                stk_mem[stk_sp] <= StkI;
                stk_sp          <= stk_sp + 1;
            end else begin
                stk_sp <= stk_sp - 1;
            end
        end
    end

    typedef struct packed {
        logic          id;
        logic          err;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] exp_rd = '0;
    logic          tb_last = 1'b1;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic id, input logic op, input logic [DW-1:0] d);
        exp_t e;
        e.id = id;
        if (!op) begin
            e.err = (ref_q.size() == DEPTH);
            if (!e.err) ref_q.push_back(d);
        end else begin
            e.err = (ref_q.size() == 0);
            if (!e.err) exp_rd = ref_q.pop_back();
        end
        e.rd = exp_rd;
        sb_q.push_back(e);
        tb_last = id;
    endtask

    function automatic logic pick_tie();
`ifdef STACK_ARB_FIXED_PRI_EN
        return 1'b0;
`else
        return ~tb_last;
`endif
    endfunction

    always @(negedge CLK) begin
        if (Reset === 1'b1 && (Ack0 || Ack1)) begin
            check_eq("ack_onehot", {31'd0, Ack0 & Ack1}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("ack_id", {31'd0, Ack1}, {31'd0, mon_e.id});
                check_eq("err", {31'd0, Err}, {31'd0, mon_e.err});
                check_eq("rddata", {24'd0, RdData}, {24'd0, mon_e.rd});
            end
        end
    end

    task automatic single_op(input logic id, input logic op, input logic [DW-1:0] d);
        logic e_err;
        bit   got;
        int   k;
        @(negedge CLK);
        predict(id, op, d);
        e_err = sb_q[$].err;
        if (id) begin Req1 = 1'b1; Op1 = op; WrData1 = d; end
        else    begin Req0 = 1'b1; Op0 = op; WrData0 = d; end
        got = 1'b0;
        for (k = 1; k <= 8 && !got; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                check_eq("issue_en", {31'd0, StkEnable}, {31'd0, !e_err});
                check_eq("busy", {31'd0, Busy}, 32'd1);
                if (!e_err) begin
                    check_eq("issue_pp", {31'd0, StkPushPop}, {31'd0, op});
                    check_eq("issue_data", {24'd0, StkI}, {24'd0, d});
                end
            end
            if (id ? Ack1 : Ack0) begin
                got = 1'b1;
                check_eq("latency", k, 32'd2);
                check_eq("ack_en_low", {31'd0, StkEnable}, 32'd0);
                Req0 = 1'b0;
                Req1 = 1'b0;
            end
        end
        if (!got) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
            Req0 = 1'b0;
            Req1 = 1'b0;
        end
    endtask

    task automatic run_both(input logic op0, input logic [DW-1:0] d0,
                            input logic op1, input logic [DW-1:0] d1, input int n);
        int   acks;
        logic id;
        @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            id = pick_tie();
            predict(id, id ? op1 : op0, id ? d1 : d0);
        end
        Req0 = 1'b1; Op0 = op0; WrData0 = d0;
        Req1 = 1'b1; Op1 = op1; WrData1 = d1;
        acks = 0;
        for (int c = 0; c < 12 * n && acks < n; c++) begin
            @(negedge CLK);
            if (Ack0 || Ack1) acks++;
            if (acks == n) begin
                Req0 = 1'b0;
                Req1 = 1'b0;
            end
        end
        if (acks != n) begin
            check_eq("both_timeout", acks, n);
            Req0 = 1'b0;
            Req1 = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        Req0 = 1'b0; Op0 = 1'b0; WrData0 = '0;
        Req1 = 1'b0; Op1 = 1'b0; WrData1 = '0;
        repeat (3) @(negedge CLK);
        check_eq("rst_ack0", {31'd0, Ack0}, 32'd0);
        check_eq("rst_ack1", {31'd0, Ack1}, 32'd0);
        check_eq("rst_err", {31'd0, Err}, 32'd0);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_en", {31'd0, StkEnable}, 32'd0);
        check_eq("rst_pp", {31'd0, StkPushPop}, 32'd0);
        check_eq("rst_stki", {24'd0, StkI}, 32'd0);
        check_eq("rst_rddata", {24'd0, RdData}, 32'd0);
        Reset = 1'b1;

        single_op(1'b0, 1'b0, 8'hA5);
        single_op(1'b1, 1'b1, 8'h00);
        single_op(1'b0, 1'b1, 8'h00);

        run_both(1'b0, 8'h01, 1'b0, 8'h02, 4);

        while (ref_q.size() < DEPTH) single_op(1'b0, 1'b0, 8'(ref_q.size()));
        @(negedge CLK);
        check_eq("full_flag", {31'd0, StkFull}, 32'd1);
        single_op(1'b1, 1'b0, 8'hFF);

        // Reset while a pop is being issued: op is lost, no Ack follows.
        @(negedge CLK);
        Req0 = 1'b1; Op0 = 1'b1; WrData0 = 8'h33;
        @(posedge CLK);
        #2;
        check_eq("pre_rst_en", {31'd0, StkEnable}, 32'd1);
        Reset = 1'b0;
        #1;
        check_eq("midrst_en", {31'd0, StkEnable}, 32'd0);
        check_eq("midrst_busy", {31'd0, Busy}, 32'd0);
        check_eq("midrst_rddata", {24'd0, RdData}, 32'd0);
        Req0 = 1'b0;
        tb_last = 1'b1;
        exp_rd  = '0;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq("no_ack_after_rst", {30'd0, Ack1, Ack0}, 32'd0);
        end
        run_both(1'b1, 8'h00, 1'b1, 8'h00, 2);

        repeat (4) @(negedge CLK);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
